onehot_scoreboard: RTL and testbench

ONEHOT_SCOREBOARD -- requirements
Module: onehot_scoreboard

---
 rtl/onehot_scoreboard.sv | 119 +++++++++++
 tb/tb_onehot_scoreboard.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_scoreboard.sv
// One-hot register busy scoreboard: tracks which entries have an outstanding
// writer. It provides operand lookups with a writeback bypass, a running busy
// count, lowest-free-entry selection and sticky protocol error flags.
module onehot_scoreboard #(
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned ZERO_LOCK = 1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   set_en,
    input  logic [ADDR_W-1:0]      set_idx,
    input  logic                   clr_en,
    input  logic [ADDR_W-1:0]      clr_idx,
    input  logic                   flush,
    input  logic [ADDR_W-1:0]      rd_a_idx,
    input  logic [ADDR_W-1:0]      rd_b_idx,
    output logic                   rd_a_busy,
    output logic                   rd_b_busy,
    output logic [(2**ADDR_W)-1:0] busy_vec,
    output logic [ADDR_W:0]        busy_count,
    output logic                   free_valid,
    output logic [ADDR_W-1:0]      free_idx,
    output logic                   err_dbl_set,
    output logic                   err_dbl_clr
);

    localparam int unsigned N = 2**ADDR_W;
    localparam bit ZL = (ZERO_LOCK != 0);
    localparam logic [N-1:0]    VEC_ONE = 1;
    localparam logic [ADDR_W:0] CNT_ONE = 1;

    logic [N-1:0]    busy_q, busy_d;
    logic [ADDR_W:0] count_q, count_d;
    logic            err_set_q, err_set_d;
    logic            err_clr_q, err_clr_d;

    logic [N-1:0] set_mask, clr_mask;
    logic         set_ok;      // set request that is allowed to change state
    logic         same_idx;
    logic         set_hit;     // target of the set is already busy
    logic         clr_hit;     // target of the clear is currently busy
    logic         inc, dec;
    logic         clr_visible; // clear that the read bypass should honour

    // Decode set/clear requests into one-hot masks; entry 0 is unsettable when locked.
    always_comb begin
        set_ok   = set_en && !(ZL && (set_idx == '0));
        set_mask = set_ok ? (VEC_ONE << set_idx) : '0;
        clr_mask = clr_en ? (VEC_ONE << clr_idx) : '0;
        same_idx = (set_idx == clr_idx);
        set_hit  = busy_q[set_idx];
        clr_hit  = busy_q[clr_idx];
    end

    // Next-state: busy vector, incremental count and sticky error flags.
    always_comb begin
        busy_d  = flush ? '0 : ((busy_q & ~clr_mask) | set_mask);

        // A set to an entry that stays busy, or a clear overridden by a
        // same-index set, leaves the population unchanged.
        inc     = set_ok && !set_hit;
        dec     = clr_en && clr_hit && !(set_ok && same_idx);
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (inc && !dec) begin
            count_d = count_q + CNT_ONE;
        end else if (dec && !inc) begin
            count_d = count_q - CNT_ONE;
        end

        err_set_d = err_set_q | (set_ok && set_hit && !(clr_en && same_idx) && !flush);
        err_clr_d = err_clr_q | (clr_en && !clr_hit && !flush);
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_q    <= '0;
            count_q   <= '0;
            err_set_q <= 1'b0;
            err_clr_q <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            count_q   <= count_d;
            err_set_q <= err_set_d;
            err_clr_q <= err_clr_d;
        end
    end

    // Operand lookups: a same-cycle writeback hides the busy bit, unless the
    // same entry is being re-issued; a same-cycle set is not forwarded.
    always_comb begin
        clr_visible = clr_en && !(set_en && same_idx);
        rd_a_busy   = !flush && busy_q[rd_a_idx] && !(clr_visible && (clr_idx == rd_a_idx));
        rd_b_busy   = !flush && busy_q[rd_b_idx] && !(clr_visible && (clr_idx == rd_b_idx));
    end

    // Lowest free allocatable entry, from registered state only.
    always_comb begin
        free_valid = 1'b0;
        free_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!busy_q[i] && !(ZL && (i == 0))) begin
                free_valid = 1'b1;
                free_idx   = ADDR_W'(i);
            end
        end
    end

    // Registered outputs.
    always_comb begin
        busy_vec    = busy_q;
        busy_count  = count_q;
        err_dbl_set = err_set_q;
        err_dbl_clr = err_clr_q;
    end

endmodule

// File: tb/tb_onehot_scoreboard.sv
// Scoreboard bench for onehot_scoreboard: the driver predicts each cycle's
// outputs from a simple array model and queues them; a monitor compares.
module tb_onehot_scoreboard;

    logic        clock;
    logic        reset_n;
    logic        set_en, clr_en, flush;
    logic [4:0]  set_idx, clr_idx, rd_a_idx, rd_b_idx;
    logic        rd_a_busy, rd_b_busy, free_valid, err_dbl_set, err_dbl_clr;
    logic [31:0] busy_vec;
    logic [5:0]  busy_count;
    logic [4:0]  free_idx;

    // Small instance (N=8) for the reduced-width directed case.
    logic       b_set_en, b_clr_en, b_flush;
    logic [2:0] b_set_idx, b_clr_idx, b_rd_a_idx, b_rd_b_idx;
    logic       b_rd_a_busy, b_rd_b_busy, b_free_valid, b_err_set, b_err_clr;
    logic [7:0] b_busy_vec;
    logic [3:0] b_busy_count;
    logic [2:0] b_free_idx;

    onehot_scoreboard #(.ADDR_W(5), .ZERO_LOCK(1)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .set_en     (set_en),
        .set_idx    (set_idx),
        .clr_en     (clr_en),
        .clr_idx    (clr_idx),
        .flush      (flush),
        .rd_a_idx   (rd_a_idx),
        .rd_b_idx   (rd_b_idx),
        .rd_a_busy  (rd_a_busy),
        .rd_b_busy  (rd_b_busy),
        .busy_vec   (busy_vec),
        .busy_count (busy_count),
        .free_valid (free_valid),
        .free_idx   (free_idx),
        .err_dbl_set(err_dbl_set),
        .err_dbl_clr(err_dbl_clr)
    );

    onehot_scoreboard #(.ADDR_W(3), .ZERO_LOCK(1)) dut_small (
        .clock      (clock),
        .reset_n    (reset_n),
        .set_en     (b_set_en),
        .set_idx    (b_set_idx),
        .clr_en     (b_clr_en),
        .clr_idx    (b_clr_idx),
        .flush      (b_flush),
        .rd_a_idx   (b_rd_a_idx),
        .rd_b_idx   (b_rd_b_idx),
        .rd_a_busy  (b_rd_a_busy),
        .rd_b_busy  (b_rd_b_busy),
        .busy_vec   (b_busy_vec),
        .busy_count (b_busy_count),
        .free_valid (b_free_valid),
        .free_idx   (b_free_idx),
        .err_dbl_set(b_err_set),
        .err_dbl_clr(b_err_clr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] vec;
        logic [5:0]  cnt;
        logic        fv;
        logic [4:0]  fi;
        logic        ra;
        logic        rb;
        logic        es;
        logic        ec;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: which registers have an outstanding writer, plus flags.
    bit m_busy[32];
    bit m_err_set, m_err_clr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t predict(input bit se, input int si, input bit ce, input int ci,
                                     input bit fl, input int ra, input int rb);
        exp_t e;
        int   n;
        n     = 0;
        e     = '0;
        for (int i = 0; i < 32; i++) begin
            e.vec[i] = m_busy[i];
            n += int'(m_busy[i]);
        end
        e.cnt = 6'(n);
        for (int i = 31; i >= 1; i--) begin
            if (!m_busy[i]) begin
                e.fv = 1'b1;
                e.fi = 5'(i);
            end
        end
        // A writeback in flight hides the entry unless it is being re-issued.
        e.ra = !fl && m_busy[ra] && !(ce && ci == ra && !(se && si == ci));
        e.rb = !fl && m_busy[rb] && !(ce && ci == rb && !(se && si == ci));
        e.es = m_err_set;
        e.ec = m_err_clr;
        return e;
    endfunction

    task automatic model_update(input bit se, input int si, input bit ce, input int ci,
                                input bit fl);
        bit real_set;
        if (fl) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        end else begin
            real_set = se && (si != 0);
            if (real_set && m_busy[si] && !(ce && ci == si)) m_err_set = 1'b1;
            if (ce && !m_busy[ci]) m_err_clr = 1'b1;
            if (ce) m_busy[ci] = 1'b0;
            if (real_set) m_busy[si] = 1'b1;  // set wins over same-index clear
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        m_err_set = 1'b0;
        m_err_clr = 1'b0;
    endtask

    // One clock of stimulus; the inputs are latched at the following rising edge.
    task automatic cycle(input bit se, input int si, input bit ce, input int ci,
                         input bit fl, input int ra, input int rb);
        @(posedge clock);
        #1;
        set_en   = se;
        set_idx  = 5'(si);
        clr_en   = ce;
        clr_idx  = 5'(ci);
        flush    = fl;
        rd_a_idx = 5'(ra);
        rd_b_idx = 5'(rb);
        exp_q.push_back(predict(se, si, ce, ci, fl, ra, rb));
        model_update(se, si, ce, ci, fl);
    endtask

    task automatic idle();
        cycle(1'b0, 0, 1'b0, 0, 1'b0, 0, 0);
    endtask

    task automatic set1(input int idx);
        cycle(1'b1, idx, 1'b0, 0, 1'b0, 0, 0);
    endtask

    task automatic spot_at_negedge();
        @(negedge clock);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 4 && exp_q.size() != 0; k++) @(negedge clock);
        #1;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_vec"}, busy_vec, 32'h0);
        check({tag, "_cnt"}, 32'(busy_count), 32'd0);
        check({tag, "_es"}, 32'(err_dbl_set), 32'd0);
        check({tag, "_ec"}, 32'(err_dbl_clr), 32'd0);
        check({tag, "_fv"}, 32'(free_valid), 32'd1);
        check({tag, "_fi"}, 32'(free_idx), 32'd1);
    endtask

    // Reset asserted between edges; inputs held active during reset must be ignored.
    task automatic do_reset();
        drain();
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_reset_values("async_rst");
        set_en  = 1'b1;
        set_idx = 5'd5;
        clr_en  = 1'b1;
        clr_idx = 5'd3;
        @(posedge clock);
        @(negedge clock);
        set_en  = 1'b0;
        clr_en  = 1'b0;
        flush   = 1'b0;
        reset_n = 1'b1;
    endtask

    // Monitor: compare every queued expectation against the DUT mid-cycle.
    always @(negedge clock) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("busy_vec", busy_vec, mon_e.vec);
            check("busy_count", 32'(busy_count), 32'(mon_e.cnt));
            check("free_valid", 32'(free_valid), 32'(mon_e.fv));
            check("free_idx", 32'(free_idx), 32'(mon_e.fi));
            check("rd_a_busy", 32'(rd_a_busy), 32'(mon_e.ra));
            check("rd_b_busy", 32'(rd_b_busy), 32'(mon_e.rb));
            check("err_dbl_set", 32'(err_dbl_set), 32'(mon_e.es));
            check("err_dbl_clr", 32'(err_dbl_clr), 32'(mon_e.ec));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int si, ci, ra, rb;
        bit se, ce, fl;

        reset_n  = 1'b0;
        set_en   = 1'b0;  set_idx  = '0;
        clr_en   = 1'b0;  clr_idx  = '0;
        flush    = 1'b0;
        rd_a_idx = '0;    rd_b_idx = '0;
        b_set_en = 1'b0;  b_set_idx = '0;
        b_clr_en = 1'b0;  b_clr_idx = '0;
        b_flush  = 1'b0;
        b_rd_a_idx = '0;  b_rd_b_idx = '0;
        model_reset();
        #1;
        check_reset_values("por");
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        // Consecutive sets 3,4,5.
        idle();
        set1(3); set1(4); set1(5); idle();
        spot_at_negedge();
        check("seq345_vec", busy_vec, 32'h38);
        check("seq345_cnt", 32'(busy_count), 32'd3);
        check("seq345_fi", 32'(free_idx), 32'd1);
        check("seq345_fv", 32'(free_valid), 32'd1);

        // Same-index set+clear keeps the entry busy; a lone clear is bypassed.
        do_reset();
        set1(0); idle();
        spot_at_negedge();
        check("zero_set_vec", busy_vec, 32'h0);
        check("zero_set_es", 32'(err_dbl_set), 32'd0);
        set1(3);
        cycle(1'b1, 3, 1'b1, 3, 1'b0, 3, 0);
        idle();
        spot_at_negedge();
        check("setclr_vec", busy_vec, 32'h8);
        check("setclr_es", 32'(err_dbl_set), 32'd0);
        check("setclr_ec", 32'(err_dbl_clr), 32'd0);
        cycle(1'b0, 0, 1'b1, 3, 1'b0, 3, 3);
        spot_at_negedge();
        check("bypass_ra", 32'(rd_a_busy), 32'd0);
        idle();

        // Fill every allocatable entry, then free one in the middle.
        do_reset();
        for (int i = 1; i < 32; i++) set1(i);
        idle();
        spot_at_negedge();
        check("full_cnt", 32'(busy_count), 32'd31);
        check("full_fv", 32'(free_valid), 32'd0);
        check("full_fi", 32'(free_idx), 32'd0);
        cycle(1'b0, 0, 1'b1, 17, 1'b0, 17, 16);
        idle();
        spot_at_negedge();
        check("clr17_fi", 32'(free_idx), 32'd17);
        check("clr17_cnt", 32'(busy_count), 32'd30);

        // Flush overrides a same-cycle set and clear.
        do_reset();
        set1(4); set1(5); set1(6); set1(7);
        cycle(1'b1, 2, 1'b1, 4, 1'b1, 5, 6);
        spot_at_negedge();
        check("flush_ra", 32'(rd_a_busy), 32'd0);
        check("flush_rb", 32'(rd_b_busy), 32'd0);
        idle();
        spot_at_negedge();
        check("flush_vec", busy_vec, 32'h0);
        check("flush_cnt", 32'(busy_count), 32'd0);

        // Sticky error flags survive flush.
        do_reset();
        set1(7); set1(7);
        cycle(1'b0, 0, 1'b1, 9, 1'b0, 0, 0);
        cycle(1'b0, 0, 1'b0, 0, 1'b1, 0, 0);
        idle();
        spot_at_negedge();
        check("sticky_es", 32'(err_dbl_set), 32'd1);
        check("sticky_ec", 32'(err_dbl_clr), 32'd1);
        check("sticky_vec", busy_vec, 32'h0);

        // Asynchronous reset from a nearly full state.
        do_reset();
        for (int i = 1; i < 16; i++) set1(i);
        idle();
        spot_at_negedge();
        check("pre_rst_vec", busy_vec, 32'hFFFE);
        do_reset();
        idle();

        // Reduced-width instance: sets 3,4,5 then fill.
        foreach (b_busy_vec[i]) begin
            if (i == 3 || i == 4 || i == 5) begin
                @(posedge clock); #1;
                b_set_en  = 1'b1;
                b_set_idx = 3'(i);
            end
        end
        @(posedge clock); #1;
        b_set_en = 1'b0;
        spot_at_negedge();
        check("small_vec", 32'(b_busy_vec), 32'h38);
        check("small_cnt", 32'(b_busy_count), 32'd3);
        check("small_fi", 32'(b_free_idx), 32'd1);
        check("small_fv", 32'(b_free_valid), 32'd1);
        foreach (b_busy_vec[i]) begin
            if (i == 1 || i == 2 || i == 6 || i == 7) begin
                @(posedge clock); #1;
                b_set_en  = 1'b1;
                b_set_idx = 3'(i);
            end
        end
        @(posedge clock); #1;
        b_set_en = 1'b0;
        spot_at_negedge();
        check("small_full_cnt", 32'(b_busy_count), 32'd7);
        check("small_full_fv", 32'(b_free_valid), 32'd0);
        check("small_full_fi", 32'(b_free_idx), 32'd0);
        check("small_full_es", 32'(b_err_set), 32'd0);

        // Randomized traffic with periodic resets to re-arm the error flags.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            if (n % 150 == 149) do_reset();
            se = ($urandom_range(0, 2) != 0);
            si = int'($urandom_range(0, 31));
            ce = ($urandom_range(0, 2) == 0);
            ci = int'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < 8; k++) begin
                    int cand;
                    cand = int'($urandom_range(0, 31));
                    if (m_busy[cand]) ci = cand;
                end
            end
            if ($urandom_range(0, 3) == 0) si = ci;
            fl = ($urandom_range(0, 39) == 0);
            ra = ($urandom_range(0, 2) == 0) ? ci : int'($urandom_range(0, 31));
            rb = int'($urandom_range(0, 31));
            cycle(se, si, ce, ci, fl, ra, rb);
        end
        idle();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
